// File: rtl/avatar_anim_ctrl_if.sv
// Key/ground inputs and sprite-control outputs exchanged between the avatar
// animation sequencer and its surroundings (motion block, color_mapper).
interface avatar_anim_ctrl_if;
  logic       frame_clk;
  logic       move_left;
  logic       move_right;
  logic       jump;
  logic       on_ground;
  logic [1:0] sprite_sel;
  logic       xFlag;
  logic       xDirection;
  logic       jump_start;
  logic [1:0] anim_state;

  // Environment side: drives keys, ground and frame strobe, observes sprite control
  modport master (
    output frame_clk, move_left, move_right, jump, on_ground,
    input  sprite_sel, xFlag, xDirection, jump_start, anim_state
  );

  // Sequencer side
  modport slave (
    input  frame_clk, move_left, move_right, jump, on_ground,
    output sprite_sel, xFlag, xDirection, jump_start, anim_state
  );
endinterface

// File: rtl/avatar_anim_ctrl.sv
// Per-frame IDLE/WALK/JUMP/LAND avatar animation sequencer; chooses the sprite
// frame and facing for color_mapper and pulses jump_start on takeoff.
module avatar_anim_ctrl #(
  parameter int unsigned STEP_FRAMES    = 8,
  parameter int unsigned MIN_AIR_FRAMES = 4,
  parameter int unsigned LAND_FRAMES    = 6
) (
  input logic               Clk,
  input logic               Reset,
  avatar_anim_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_FRAMES - 1);
  localparam logic [CNT_W-1:0] AIR_LAST  = CNT_W'(MIN_AIR_FRAMES - 1);
  localparam logic [CNT_W-1:0] LAND_LAST = CNT_W'(LAND_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_JUMP = 2'd2,
    ST_LAND = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             facing_q, facing_d;
  logic             frame_clk_d_q;
  logic             jump_start_q, jump_start_d;
  logic [1:0]       sprite_sel_q, sprite_sel_d;
  logic             xflag_q;

  logic tick;
  logic one_dir;
  logic takeoff;

  assign tick    = bus.frame_clk & ~frame_clk_d_q;
  assign one_dir = bus.move_left ^ bus.move_right;
  assign takeoff = bus.jump & bus.on_ground;

  // Next-state evaluation; everything holds between frame ticks
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    facing_d     = facing_q;
    jump_start_d = 1'b0;
    if (tick) begin
      if (bus.move_left & ~bus.move_right) begin
        facing_d = 1'b1;
      end else if (bus.move_right & ~bus.move_left) begin
        facing_d = 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (takeoff) begin
            state_d      = ST_JUMP;
            cnt_d        = '0;
            jump_start_d = 1'b1;
          end else if (one_dir) begin
            state_d = ST_WALK;
            cnt_d   = '0;
            phase_d = 1'b0;
          end
        end
        ST_WALK: begin
          if (takeoff) begin
            state_d      = ST_JUMP;
            cnt_d        = '0;
            jump_start_d = 1'b1;
          end else if (!one_dir) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
          end else if (cnt_q == STEP_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_JUMP: begin
          // jump key is deliberately ignored here: no double jump
          if (bus.on_ground && (cnt_q >= AIR_LAST)) begin
            state_d = ST_LAND;
            cnt_d   = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LAND: begin
          if (cnt_q == LAND_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sprite decode from the upcoming state so the select lines are registered
  always_comb begin
    sprite_sel_d = 2'd0;
    unique case (state_d)
      ST_WALK: sprite_sel_d = phase_d ? 2'd2 : 2'd1;
      ST_JUMP: sprite_sel_d = 2'd2;
      default: sprite_sel_d = 2'd0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      phase_q       <= 1'b0;
      facing_q      <= 1'b0;
      frame_clk_d_q <= 1'b0;
      jump_start_q  <= 1'b0;
      sprite_sel_q  <= 2'd0;
      xflag_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      facing_q      <= facing_d;
      frame_clk_d_q <= bus.frame_clk;
      jump_start_q  <= jump_start_d;
      sprite_sel_q  <= sprite_sel_d;
      xflag_q       <= |sprite_sel_d;
    end
  end

  assign bus.sprite_sel = sprite_sel_q;
  assign bus.xFlag      = xflag_q;
  assign bus.xDirection = facing_q;
  assign bus.jump_start = jump_start_q;
  assign bus.anim_state = state_q;

endmodule

// File: tb/tb_avatar_anim_ctrl.sv
// Scoreboard bench for avatar_anim_ctrl: a reference model pushes expected
// outputs per cycle, which are popped and compared after each clock edge.
module tb_avatar_anim_ctrl;

  localparam int unsigned STEP  = 8;
  localparam int unsigned AIR   = 4;
  localparam int unsigned LANDF = 6;

  logic Clk = 1'b0;
  logic Reset = 1'b0;

  avatar_anim_ctrl_if bus ();

  avatar_anim_ctrl #(
    .STEP_FRAMES   (STEP),
    .MIN_AIR_FRAMES(AIR),
    .LAND_FRAMES   (LANDF)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  always #10 Clk = ~Clk;

  typedef struct packed {
    logic [1:0] sprite;
    logic       xflag;
    logic       xdir;
    logic       js;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int m_state  = 0;
  int m_cnt    = 0;
  bit m_phase  = 1'b0;
  bit m_facing = 1'b0;
  bit m_prev   = 1'b0;
  bit m_js     = 1'b0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_cycle(input bit rst, input bit fc, input bit ml, input bit mr,
                             input bit jp, input bit og);
    exp_t e;
    if (!rst) begin
      m_state = 0; m_cnt = 0; m_phase = 0; m_facing = 0; m_prev = 0; m_js = 0;
    end else begin
      m_js = 0;
      if (fc && !m_prev) begin
        if (ml && !mr) m_facing = 1;
        else if (mr && !ml) m_facing = 0;
        case (m_state)
          0: if (jp && og) begin m_state = 2; m_cnt = 0; m_js = 1; end
             else if (ml != mr) begin m_state = 1; m_cnt = 0; m_phase = 0; end
          1: if (jp && og) begin m_state = 2; m_cnt = 0; m_js = 1; end
             else if (ml == mr) begin m_state = 0; m_cnt = 0; m_phase = 0; end
             else if (m_cnt == int'(STEP) - 1) begin m_cnt = 0; m_phase = !m_phase; end
             else m_cnt++;
          2: if (og && m_cnt >= int'(AIR) - 1) begin m_state = 3; m_cnt = 0; end
             else if (m_cnt < 255) m_cnt++;
          default: if (m_cnt == int'(LANDF) - 1) begin m_state = 0; m_cnt = 0; end
                   else m_cnt++;
        endcase
      end
      m_prev = fc;
    end
    e.sprite = (m_state == 1) ? (m_phase ? 2'd2 : 2'd1) : (m_state == 2) ? 2'd2 : 2'd0;
    e.xflag  = (e.sprite != 2'd0);
    e.xdir   = m_facing;
    e.js     = m_js;
    e.st     = 2'(m_state);
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, predict, then compare after the edge
  task automatic cycle(input bit rst, input bit fc, input bit ml, input bit mr,
                       input bit jp, input bit og);
    exp_t e;
    @(negedge Clk);
    Reset          = rst;
    bus.frame_clk  = fc;
    bus.move_left  = ml;
    bus.move_right = mr;
    bus.jump       = jp;
    bus.on_ground  = og;
    model_cycle(rst, fc, ml, mr, jp, og);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_eq("sprite_sel", bus.sprite_sel, e.sprite);
      check_eq("xFlag", bus.xFlag, e.xflag);
      check_eq("xDirection", bus.xDirection, e.xdir);
      check_eq("jump_start", bus.jump_start, e.js);
      check_eq("anim_state", bus.anim_state, e.st);
    end
  endtask

  task automatic frame(input bit ml, input bit mr, input bit jp, input bit og);
    cycle(1'b1, 1'b1, ml, mr, jp, og);
    cycle(1'b1, 1'b0, ml, mr, jp, og);
  endtask

  initial begin
    bus.frame_clk = 1'b0; bus.move_left = 1'b0; bus.move_right = 1'b0;
    bus.jump = 1'b0; bus.on_ground = 1'b0;

    // Reset with the strobe toggling, then release with no tick
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Walk right through two phase toggles, then release
    for (int i = 0; i < 20; i++) frame(1'b0, 1'b1, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 1'b1);

    // Facing: left, then both keys
    frame(1'b1, 1'b0, 1'b0, 1'b1);
    frame(1'b1, 1'b1, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 1'b1);

    // Jump from WALK with jump and ground held throughout
    frame(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) frame(1'b0, 1'b1, 1'b1, 1'b1);

    // Jump with ground released: saturating air time, then landing
    frame(1'b0, 1'b0, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 260; i++) frame(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) frame(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-jump, released with strobe already high
    frame(1'b0, 1'b0, 1'b1, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Strobe held high for 1000 cycles: one advance only
    frame(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1000; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Random strobe and key activity, including pulses between ticks
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
